// File: rtl/i2c_arb_pkg.sv
// Shared state encoding, descriptor field widths and width helper for the
// I2C request arbiter.
package i2c_arb_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LAUNCH     = 3'd1,
      WAIT_START = 3'd2,
      WAIT_DONE  = 3'd3,
      DONE       = 3'd4
   } arb_state_t;

   localparam int unsigned ADDR_W  = 7;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned BYTES_W = 4;

   // Bits needed to index n items; never less than one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin search: first asserted request at or after
// rr_ptr, wrapping modulo NUM_REQ.
module rr_priority_select
   import i2c_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]           req,
   input  logic [width_of(NUM_REQ)-1:0] rr_ptr,
   output logic [width_of(NUM_REQ)-1:0] winner,
   output logic                         any_valid
);

   localparam int unsigned W = width_of(NUM_REQ);

   logic [W-1:0] idx;

   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      idx       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = W'((32'(rr_ptr) + k) % NUM_REQ);
         if (!any_valid && req[idx]) begin
            any_valid = 1'b1;
            winner    = idx;
         end
      end
   end

endmodule

// File: rtl/i2c_request_arbiter.sv
// Round-robin sharing of one I2C controller among NUM_REQ requesters, with
// start and completion timeouts reported back to the granted requester.
module i2c_request_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned START_WAIT   = 16,
   parameter int unsigned DONE_TIMEOUT = 65535
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_rw,
   input  logic [ADDR_W*NUM_REQ-1:0]     req_address,
   input  logic [DATA_W*NUM_REQ-1:0]     req_data,
   input  logic [BYTES_W*NUM_REQ-1:0]    req_bytesend,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            req_done,
   output logic                          req_err,
   output logic                          busy,
   output logic [width_of(NUM_REQ)-1:0]  grant_id,
   output logic                          ctl_init_transaction,
   output logic                          ctl_rw,
   output logic [ADDR_W-1:0]             ctl_address,
   output logic [DATA_W-1:0]             ctl_data,
   output logic [BYTES_W-1:0]            ctl_bytesend,
   input  logic                          ctl_idle
);

   localparam int unsigned GW = width_of(NUM_REQ);
   localparam int unsigned CW = width_of(DONE_TIMEOUT + 1);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("i2c_request_arbiter: NUM_REQ must be within 2..8");
   end

   arb_state_t state, state_nxt;

   logic [GW-1:0]      rr_ptr;
   logic [GW-1:0]      sel_idx;
   logic               any_valid;
   logic [CW-1:0]      cnt;
   logic               err_q, err_nxt;
   logic               accept;

   logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]  data_arr  [NUM_REQ];
   logic [BYTES_W-1:0] bytes_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = req_address[g*ADDR_W +: ADDR_W];
      assign data_arr[g]  = req_data[g*DATA_W +: DATA_W];
      assign bytes_arr[g] = req_bytesend[g*BYTES_W +: BYTES_W];
   end

   rr_priority_select #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_select (
      .req       (req_valid),
      .rr_ptr    (rr_ptr),
      .winner    (sel_idx),
      .any_valid (any_valid)
   );

   // A grant also needs the controller back in IDLE, not merely quiet.
   assign accept = (state == IDLE) && any_valid && ctl_idle;

   always_ff @(posedge clock) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = err_q;
      case (state)
         IDLE:       if (accept) state_nxt = LAUNCH;
         LAUNCH: begin
            state_nxt = WAIT_START;
            err_nxt   = 1'b0;
         end
         WAIT_START: begin
            if (!ctl_idle) begin
               state_nxt = WAIT_DONE;
            end else if (cnt == CW'(START_WAIT - 1)) begin
               state_nxt = DONE;
               err_nxt   = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (ctl_idle) begin
               state_nxt = DONE;
               err_nxt   = 1'b0;
            end else if (cnt == CW'(DONE_TIMEOUT - 1)) begin
               state_nxt = DONE;
               err_nxt   = 1'b1;
            end
         end
         DONE:       state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rr_ptr       <= '0;
         grant_id     <= '0;
         cnt          <= '0;
         err_q        <= 1'b0;
         ctl_rw       <= 1'b0;
         ctl_address  <= '0;
         ctl_data     <= '0;
         ctl_bytesend <= '0;
      end else begin
         err_q <= err_nxt;
         case (state)
            IDLE: begin
               if (accept) begin
                  grant_id     <= sel_idx;
                  ctl_rw       <= req_rw[sel_idx];
                  ctl_address  <= addr_arr[sel_idx];
                  ctl_data     <= data_arr[sel_idx];
                  ctl_bytesend <= bytes_arr[sel_idx];
               end
            end
            LAUNCH: cnt <= '0;
            // Counter restarts on the WAIT_START -> WAIT_DONE hop and saturates otherwise.
            WAIT_START, WAIT_DONE: begin
               if (state_nxt != state) cnt <= '0;
               else if (cnt != '1)     cnt <= cnt + 1'b1;
            end
            DONE: rr_ptr <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      req_ready            = '0;
      req_done             = '0;
      req_err              = 1'b0;
      ctl_init_transaction = 1'b0;
      busy                 = (state != IDLE);
      case (state)
         LAUNCH: begin
            req_ready[grant_id]  = 1'b1;
            ctl_init_transaction = 1'b1;
         end
         DONE: begin
            req_done[grant_id] = 1'b1;
            req_err            = err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_i2c_request_arbiter.sv
// Directed bench for i2c_request_arbiter: 4 requesters, START_WAIT=16,
// DONE_TIMEOUT shortened to 100 so the completion timeout is reachable.
module tb_i2c_request_arbiter;

   logic         clock;
   logic         reset_n;
   logic [3:0]   req_valid;
   logic [3:0]   req_rw;
   logic [27:0]  req_address;
   logic [127:0] req_data;
   logic [15:0]  req_bytesend;
   logic [3:0]   req_ready;
   logic [3:0]   req_done;
   logic         req_err;
   logic         busy;
   logic [1:0]   grant_id;
   logic         ctl_init_transaction;
   logic         ctl_rw;
   logic [6:0]   ctl_address;
   logic [31:0]  ctl_data;
   logic [3:0]   ctl_bytesend;
   logic         ctl_idle;

   int total = 0;
   int bad   = 0;

   i2c_request_arbiter #(
      .NUM_REQ      (4),
      .START_WAIT   (16),
      .DONE_TIMEOUT (100)
   ) dut (
      .clock                (clock),
      .reset_n              (reset_n),
      .req_valid            (req_valid),
      .req_rw               (req_rw),
      .req_address          (req_address),
      .req_data             (req_data),
      .req_bytesend         (req_bytesend),
      .req_ready            (req_ready),
      .req_done             (req_done),
      .req_err              (req_err),
      .busy                 (busy),
      .grant_id             (grant_id),
      .ctl_init_transaction (ctl_init_transaction),
      .ctl_rw               (ctl_rw),
      .ctl_address          (ctl_address),
      .ctl_data             (ctl_data),
      .ctl_bytesend         (ctl_bytesend),
      .ctl_idle             (ctl_idle)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drives one request set, plays the controller (idle low for 'hold' cycles
   // after launch, or never when hold==0) and returns what was observed.
   task automatic xfer(input logic [3:0] v, input int hold,
                       output logic [1:0] gid, output logic [3:0] rdy,
                       output logic [3:0] dn, output logic er,
                       output int wait_n, output int lc, output bit ok);
      ok = 1'b1; gid = '0; rdy = '0; dn = '0; er = 1'b0; wait_n = 0; lc = 0;
      req_valid = v;
      while (ctl_init_transaction !== 1'b1 && wait_n < 20) begin
         tick();
         wait_n++;
      end
      if (ctl_init_transaction !== 1'b1) begin
         ok = 1'b0;
         req_valid = '0;
         return;
      end
      gid = grant_id;
      rdy = req_ready;
      ctl_idle = (hold == 0);
      while (req_done === 4'b0000 && lc < 300) begin
         tick();
         lc++;
         if (lc == hold) ctl_idle = 1'b1;
      end
      dn = req_done;
      er = req_err;
      if (req_done === 4'b0000) ok = 1'b0;
      req_valid = '0;
   endtask

   task automatic test_reset();
      logic [56:0] outs;
      reset_n = 1'b0; req_valid = '0; req_rw = '0; req_address = '0;
      req_data = '0; req_bytesend = '0; ctl_idle = 1'b1;
      tick(); tick();
      outs = {busy, req_ready, req_done, req_err, grant_id, ctl_init_transaction,
              ctl_rw, ctl_address, ctl_data, ctl_bytesend};
      total++;
      if (outs !== 57'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %h, want 0", outs);
      end
      reset_n = 1'b1;
      tick();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] gid; logic [3:0] rdy, dn; logic er; int wn, lc; bit ok;
      logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      for (int k = 0; k < 5; k++) begin
         xfer(4'b1111, 2, gid, rdy, dn, er, wn, lc, ok);
         total++;
         if (!ok || gid !== exp_g[k] || rdy !== (4'b0001 << exp_g[k]) ||
             dn !== (4'b0001 << exp_g[k]) || er !== 1'b0) begin
            bad++;
            $display("FAIL rr_grant%0d: ok=%0d gid=%0d rdy=%b done=%b err=%b, want gid=%0d one-hot err=0",
                     k, ok, gid, rdy, dn, er, exp_g[k]);
         end
         total++;
         if (lc !== 3) begin
            bad++;
            $display("FAIL rr_min_latency%0d: launch->done=%0d, want 3", k, lc);
         end
         total++;
         if (wn !== ((k == 0) ? 1 : 2)) begin
            bad++;
            $display("FAIL back_to_back%0d: cycles to launch=%0d, want %0d",
                     k, wn, (k == 0) ? 1 : 2);
         end
      end
   endtask

   task automatic test_single();
      tick();
      total++;
      if (busy !== 1'b0 || ctl_init_transaction !== 1'b0) begin
         bad++;
         $display("FAIL single_pre_idle: busy=%b init=%b, want 0 0", busy, ctl_init_transaction);
      end
      req_rw[2] = 1'b1;
      req_address[14 +: 7] = 7'h50;
      req_data[64 +: 32] = 32'hCAFE_0102;
      req_bytesend[8 +: 4] = 4'd2;
      req_address[0 +: 7] = 7'h33;
      req_valid = 4'b0100;
      tick();
      total++;
      if (req_ready !== 4'b0100 || ctl_init_transaction !== 1'b1 || grant_id !== 2'd2) begin
         bad++;
         $display("FAIL single_launch: ready=%b init=%b gid=%0d, want 0100 1 2",
                  req_ready, ctl_init_transaction, grant_id);
      end
      total++;
      if (ctl_address !== 7'h50 || ctl_rw !== 1'b1 || ctl_bytesend !== 4'd2 ||
          ctl_data !== 32'hCAFE_0102) begin
         bad++;
         $display("FAIL single_fields: addr=%h rw=%b bytes=%0d data=%h, want 50 1 2 cafe0102",
                  ctl_address, ctl_rw, ctl_bytesend, ctl_data);
      end
      req_valid = 4'b0000;
      req_address[14 +: 7] = 7'h11;
      req_rw[2] = 1'b0;
      ctl_idle = 1'b0;
      tick();
      total++;
      if (req_ready !== 4'b0000 || ctl_init_transaction !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL single_one_cycle: ready=%b init=%b busy=%b, want 0000 0 1",
                  req_ready, ctl_init_transaction, busy);
      end
      for (int i = 1; i < 40; i++) tick();
      ctl_idle = 1'b1;
      tick();
      total++;
      if (req_done !== 4'b0100 || req_err !== 1'b0) begin
         bad++;
         $display("FAIL single_done: done=%b err=%b, want 0100 0", req_done, req_err);
      end
      tick();
      total++;
      if (req_done !== 4'b0000 || busy !== 1'b0 || ctl_address !== 7'h50 || ctl_rw !== 1'b1) begin
         bad++;
         $display("FAIL single_hold: done=%b busy=%b addr=%h rw=%b, want 0000 0 50 1",
                  req_done, busy, ctl_address, ctl_rw);
      end
   endtask

   task automatic test_wrap();
      logic [1:0] gid; logic [3:0] rdy, dn; logic er; int wn, lc; bit ok;
      xfer(4'b1001, 2, gid, rdy, dn, er, wn, lc, ok);
      total++;
      if (!ok || gid !== 2'd3 || dn !== 4'b1000) begin
         bad++;
         $display("FAIL wrap_first: ok=%0d gid=%0d done=%b, want 3 1000", ok, gid, dn);
      end
      xfer(4'b1001, 2, gid, rdy, dn, er, wn, lc, ok);
      total++;
      if (!ok || gid !== 2'd0 || dn !== 4'b0001) begin
         bad++;
         $display("FAIL wrap_second: ok=%0d gid=%0d done=%b, want 0 0001", ok, gid, dn);
      end
   endtask

   task automatic test_start_timeout();
      logic [1:0] gid; logic [3:0] rdy, dn; logic er; int wn, lc; bit ok;
      xfer(4'b0110, 0, gid, rdy, dn, er, wn, lc, ok);
      total++;
      if (!ok || gid !== 2'd1 || dn !== 4'b0010 || er !== 1'b1) begin
         bad++;
         $display("FAIL start_timeout: ok=%0d gid=%0d done=%b err=%b, want 1 0010 1",
                  ok, gid, dn, er);
      end
      total++;
      if (lc !== 17) begin
         bad++;
         $display("FAIL start_timeout_time: launch->done=%0d, want 17", lc);
      end
      xfer(4'b0110, 2, gid, rdy, dn, er, wn, lc, ok);
      total++;
      if (!ok || gid !== 2'd2 || er !== 1'b0) begin
         bad++;
         $display("FAIL start_timeout_advance: ok=%0d gid=%0d err=%b, want 2 0", ok, gid, er);
      end
   endtask

   task automatic test_done_timeout();
      logic [1:0] gid; logic [3:0] rdy, dn; logic er; int wn, lc; bit ok;
      xfer(4'b0001, 500, gid, rdy, dn, er, wn, lc, ok);
      total++;
      if (!ok || gid !== 2'd0 || dn !== 4'b0001 || er !== 1'b1) begin
         bad++;
         $display("FAIL done_timeout: ok=%0d gid=%0d done=%b err=%b, want 0 0001 1",
                  ok, gid, dn, er);
      end
      total++;
      if (lc !== 102) begin
         bad++;
         $display("FAIL done_timeout_time: launch->done=%0d, want 102", lc);
      end
      req_valid = 4'b0001;
      tick(); tick(); tick();
      total++;
      if (ctl_init_transaction !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL ctl_busy_no_grant: init=%b busy=%b, want 0 0", ctl_init_transaction, busy);
      end
      ctl_idle = 1'b1;
      tick();
      total++;
      if (ctl_init_transaction !== 1'b1 || req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL grant_after_idle: init=%b ready=%b, want 1 0001",
                  ctl_init_transaction, req_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic [56:0] outs;
      logic [1:0] gid; logic [3:0] rdy, dn; logic er; int wn, lc; bit ok;
      logic [3:0] seen_done;
      req_valid = 4'b0000;
      ctl_idle = 1'b0;
      tick(); tick(); tick();
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_busy: busy=%b, want 1", busy);
      end
      reset_n = 1'b0;
      tick();
      outs = {busy, req_ready, req_done, req_err, grant_id, ctl_init_transaction,
              ctl_rw, ctl_address, ctl_data, ctl_bytesend};
      total++;
      if (outs !== 57'd0) begin
         bad++;
         $display("FAIL mid_reset_outputs: got %h, want 0", outs);
      end
      ctl_idle = 1'b1;
      tick();
      reset_n = 1'b1;
      seen_done = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         seen_done |= req_done;
      end
      total++;
      if (seen_done !== 4'b0000) begin
         bad++;
         $display("FAIL mid_no_done: done seen=%b, want 0000", seen_done);
      end
      xfer(4'b1111, 2, gid, rdy, dn, er, wn, lc, ok);
      total++;
      if (!ok || gid !== 2'd0 || dn !== 4'b0001 || er !== 1'b0) begin
         bad++;
         $display("FAIL mid_fresh_grant: ok=%0d gid=%0d done=%b err=%b, want 0 0001 0",
                  ok, gid, dn, er);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_wrap();
      test_start_timeout();
      test_done_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
